// File: rtl/memory_arbiter_pkg.sv
// Shared types and limits for the N-port memory arbiter and its bus interface.
package memory_arbiter_pkg;

  localparam int MEMORY_ARBITER_MAX_PORTS = 8;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2
  } memory_arbiter_n_state_t;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wr_data;
  } mem_req_t;

endpackage

// File: rtl/memory_interface.sv
// Valid/ready memory bus: master drives the request, slave answers with ready and rd_data.
interface memory_interface;
  import memory_arbiter_pkg::*;

  logic                  valid;
  logic                  ready;
  logic                  write;
  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_DATA_W-1:0] wr_data;
  logic [MEM_DATA_W-1:0] rd_data;

  modport master (output valid, addr, wr_data, write, input  ready, rd_data);
  modport slave  (input  valid, addr, wr_data, write, output ready, rd_data);

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational winner select: scan starts at port 0 (fixed) or last+1 wrapping (round-robin).
module rr_priority_picker #(
  parameter int NUM_PORTS = 2,
  parameter int GRANT_W   = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GRANT_W-1:0]   last,
  input  logic                 rr_en,
  output logic                 found,
  output logic [GRANT_W-1:0]   idx
);

  logic [GRANT_W-1:0] start;
  logic [GRANT_W-1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    start = '0;
    if (rr_en)
      start = (int'(last) + 1 >= NUM_PORTS) ? '0 : last + GRANT_W'(1);
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = GRANT_W'((int'(start) + i) % NUM_PORTS);
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter_n.sv
// N-port memory bus arbiter, one outstanding transaction, registered grant.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0 highest).
module memory_arbiter_n
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int GRANT_W   = $clog2(NUM_PORTS)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  memory_interface.slave     req_bus [NUM_PORTS],
  memory_interface.master    memory_bus,
  output logic               grant_valid_o,
  output logic [GRANT_W-1:0] grant_id_o
);

  if (NUM_PORTS < 2 || NUM_PORTS > MEMORY_ARBITER_MAX_PORTS) begin : g_bad_ports
    $error("memory_arbiter_n: NUM_PORTS must be 2..8");
  end

  memory_arbiter_n_state_t state_q, state_d;
  logic [GRANT_W-1:0]      grant_q, grant_d;

  logic [NUM_PORTS-1:0]    req_vld;
  mem_req_t [NUM_PORTS-1:0] req_pkt;
  logic [NUM_PORTS-1:0]    port_ready;

  logic                    mem_valid;
  mem_req_t                mem_req;

  logic                    pick_found;
  logic [GRANT_W-1:0]      pick_idx;
  logic [GRANT_W-1:0]      pick_last;
  logic                    pick_rr_en;

  // Flatten the interface array so the grant can index it dynamically.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign req_vld[g]         = req_bus[g].valid;
    assign req_pkt[g]         = '{write: req_bus[g].write, addr: req_bus[g].addr,
                                  wr_data: req_bus[g].wr_data};
    assign req_bus[g].ready   = port_ready[g];
    assign req_bus[g].rd_data = memory_bus.rd_data;
  end

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic [GRANT_W-1:0] last_grant_q;

  // Resetting to the top port makes port 0 the first round-robin winner.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      last_grant_q <= GRANT_W'(NUM_PORTS - 1);
    else if (state_q == READY && state_d == REQUEST)
      last_grant_q <= pick_idx;
  end

  assign pick_last  = last_grant_q;
  assign pick_rr_en = 1'b1;
`else
  assign pick_last  = '0;
  assign pick_rr_en = 1'b0;
`endif

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .GRANT_W   (GRANT_W)
  ) u_picker (
    .req   (req_vld),
    .last  (pick_last),
    .rr_en (pick_rr_en),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= READY;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_valid  = 1'b0;
    mem_req    = '0;
    port_ready = '0;
    case (state_q)
      READY: begin
        if (memory_bus.ready && pick_found) begin
          state_d = REQUEST;
          grant_d = pick_idx;
        end
      end
      REQUEST: begin
        mem_valid = 1'b1;
        mem_req   = req_pkt[grant_q];
        if (!memory_bus.ready)
          state_d = WAIT;
      end
      WAIT: begin
        // valid stays low here so the memory never sees a second issue.
        mem_req = req_pkt[grant_q];
        if (memory_bus.ready) begin
          port_ready[grant_q] = 1'b1;
          state_d             = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  assign memory_bus.valid   = mem_valid;
  assign memory_bus.addr    = mem_req.addr;
  assign memory_bus.wr_data = mem_req.wr_data;
  assign memory_bus.write   = mem_req.write;

  assign grant_valid_o = (state_q != READY);
  assign grant_id_o    = grant_valid_o ? grant_q : '0;

endmodule

// File: tb/tb_memory_arbiter_n.sv
// Scoreboard bench for memory_arbiter_n with 4 ports and a behavioural busy-counting memory.
module tb_memory_arbiter_n;

  localparam int NP = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        grant_valid_o;
  logic [1:0]  grant_id_o;

  memory_interface req_if [NP] ();
  memory_interface mem_if ();

  logic [NP-1:0] tb_valid, tb_wr, tb_ready;
  logic [31:0]   tb_addr [NP];
  logic [31:0]   tb_wd   [NP];
  logic [31:0]   tb_rd   [NP];

  for (genvar g = 0; g < NP; g++) begin : g_req
    assign req_if[g].valid   = tb_valid[g];
    assign req_if[g].addr    = tb_addr[g];
    assign req_if[g].wr_data = tb_wd[g];
    assign req_if[g].write   = tb_wr[g];
    assign tb_ready[g]       = req_if[g].ready;
    assign tb_rd[g]          = req_if[g].rd_data;
  end

  memory_arbiter_n #(.NUM_PORTS(NP)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_bus       (req_if),
    .memory_bus    (mem_if),
    .grant_valid_o (grant_valid_o),
    .grant_id_o    (grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: ready low for mem_busy cycles after accepting, then returns a data word.
  int          mem_busy = 1;
  int          m_cnt;
  logic        m_ready;
  logic [31:0] m_pend, m_rd;

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_rd    <= '0;
      m_pend  <= '0;
    end else if (m_ready && mem_if.valid) begin
      m_ready <= 1'b0;
      m_cnt   <= mem_busy;
      m_pend  <= (mem_if.addr == 32'h100) ? 32'hDEADBEEF
                 : (~mem_if.addr ^ mem_if.wr_data ^ {31'b0, mem_if.write});
    end else if (!m_ready) begin
      if (m_cnt <= 1) begin
        m_ready <= 1'b1;
        m_rd    <= m_pend;
      end else
        m_cnt <= m_cnt - 1;
    end
  end
  assign mem_if.ready   = m_ready;
  assign mem_if.rd_data = m_rd;

  // Requester state: each port issues rem[k] requests at bases[k] + 4*j.
  int          rem [NP];
  int          cnt [NP];
  logic [31:0] bases [NP];

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] wd;
    wd = a * 3;
    return ~a ^ wd ^ {31'b0, a[2]};
  endfunction

  task automatic set_req(input int k);
    logic [31:0] a;
    a = bases[k] + 32'(4 * cnt[k]);
    tb_addr[k] = a;
    tb_wd[k]   = a * 3;
    tb_wr[k]   = a[2];
  endtask

  task automatic start(input int k, input int n, input logic [31:0] base);
    rem[k]   = n;
    cnt[k]   = 0;
    bases[k] = base;
    set_req(k);
    tb_valid[k] = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] pulsed;
    forever begin
      @(negedge clk_i);
      pulsed = tb_ready & tb_valid;
      if (pulsed != '0) begin
        @(posedge clk_i); #1;
        for (int k = 0; k < NP; k++)
          if (pulsed[k]) begin
            rem[k]--;
            cnt[k]++;
            if (rem[k] > 0) set_req(k);
            else tb_valid[k] = 1'b0;
          end
      end
    end
  end

  // Scoreboard
  typedef struct { int port; logic [31:0] data; } exp_t;
  exp_t exp_q [$];
  int   seq [$];
  int   pulse_q [$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  bit   mon_en = 1'b0;

  task automatic push_seq();
    int occ [NP];
    for (int k = 0; k < NP; k++) occ[k] = 0;
    foreach (seq[i]) begin
      exp_q.push_back('{seq[i], exp_data(bases[seq[i]] + 32'(4 * occ[seq[i]]))});
      occ[seq[i]]++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (mon_en && !reset_i) begin
        for (int k = 0; k < NP; k++)
          if (tb_ready[k]) begin
            n_cmp++;
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_pulse port=%0d data=%0h", k, tb_rd[k]);
            end else begin
              e = exp_q.pop_front();
              if (k != e.port || tb_rd[k] !== e.data || int'(grant_id_o) != k) begin
                n_err++;
                $display("FAIL pulse actual port=%0d data=%0h gid=%0d required port=%0d data=%0h",
                         k, tb_rd[k], grant_id_o, e.port, e.data);
              end
            end
          end
        if (!grant_valid_o) begin
          n_cmp++;
          if (mem_if.valid || mem_if.addr != 0 || mem_if.wr_data != 0 || mem_if.write ||
              grant_id_o != 0 || tb_ready != 0) begin
            n_err++;
            $display("FAIL idle_outputs actual valid=%0b addr=%0h gid=%0d ready=%0b required all 0",
                     mem_if.valid, mem_if.addr, grant_id_o, tb_ready);
          end
        end
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while ((exp_q.size() != 0 || grant_valid_o) && t < 2000);
    chk("drain_timeout", 32'(t >= 2000), 0);
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  initial begin
    int t;
    reset_i  = 1'b1;
    tb_valid = '0;
    for (int k = 0; k < NP; k++) begin
      tb_addr[k] = '0; tb_wd[k] = '0; tb_wr[k] = 1'b0; rem[k] = 0; cnt[k] = 0; bases[k] = '0;
    end

    // Reset held with every port requesting: nothing issues, port 0 wins first.
    for (int k = 0; k < NP; k++) start(k, 1, 32'h1000 * 32'(k + 1));
    repeat (2) @(posedge clk_i);
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_mem_valid", 32'(mem_if.valid), 0);
      chk("rst_grant_valid", 32'(grant_valid_o), 0);
      chk("rst_ready", 32'(tb_ready), 0);
    end
    seq = '{0, 1, 2, 3};
    push_seq();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("first_no_comb_valid", 32'(mem_if.valid), 0);
    @(negedge clk_i);
    chk("first_grant_valid", 32'(grant_valid_o), 1);
    chk("first_grant_id", 32'(grant_id_o), 0);
    wait_done();

    // Single read on port 1, memory busy 3 cycles.
    mem_busy = 3;
    start(1, 1, 32'h100);
    exp_q.push_back('{1, 32'hDEADBEEF});
    @(negedge clk_i);
    chk("lat_no_comb_valid", 32'(mem_if.valid), 0);
    @(negedge clk_i);
    chk("lat_mem_valid", 32'(mem_if.valid), 1);
    chk("lat_grant_id", 32'(grant_id_o), 1);
    chk("lat_addr", mem_if.addr, 32'h100);
    wait_done();
    chk("single_back_ready", 32'(grant_valid_o), 0);

    // Ports 0 (4 requests) and 1 (1 request) contend, memory busy 1 cycle.
    do_reset();
    mem_busy = 1;
    pulse_q.delete();
    start(0, 4, 32'h2000);
    start(1, 1, 32'h3000);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 0, 0};
`else
    seq = '{0, 0, 0, 0, 1};
`endif
    push_seq();
    wait_done();
    chk("b2b_pulse_count", 32'(pulse_q.size()), 5);
    for (int i = 1; i < pulse_q.size(); i++)
      chk("b2b_period", 32'(pulse_q[i] - pulse_q[i-1]), 4);

    // All four ports, two requests each.
    do_reset();
    for (int k = 0; k < NP; k++) start(k, 2, 32'h5000 + 32'h100 * 32'(k));
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    seq = '{0, 0, 1, 1, 2, 2, 3, 3};
`endif
    push_seq();
    wait_done();

    // Only ports 1 and 3, memory busy 2 cycles.
    do_reset();
    mem_busy = 2;
    start(1, 2, 32'h6000);
    start(3, 2, 32'h7000);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    seq = '{1, 3, 1, 3};
`else
    seq = '{1, 1, 3, 3};
`endif
    push_seq();
    wait_done();

    // Reset while the transaction sits in WAIT, then a fresh request.
    mem_busy = 3;
    start(2, 1, 32'h8000);
    seq = '{2};
    push_seq();
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!(grant_valid_o && !mem_if.valid) && t < 50);
    chk("reach_wait_timeout", 32'(t >= 50), 0);
    reset_i     = 1'b1;
    tb_valid[2] = 1'b0;
    rem[2]      = 0;
    exp_q.delete();
    @(negedge clk_i);
    chk("rstwait_mem_valid", 32'(mem_if.valid), 0);
    chk("rstwait_grant_valid", 32'(grant_valid_o), 0);
    chk("rstwait_grant_id", 32'(grant_id_o), 0);
    chk("rstwait_ready", 32'(tb_ready), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    start(3, 1, 32'h9000);
    seq = '{3};
    push_seq();
    wait_done();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter_n.md
# memory_arbiter_n

Parametrised N-port arbiter for the shared memory bus: muxes `NUM_PORTS` requester `memory_interface` ports (icache, dcache, future DMA/debug masters) onto one `memory_interface` master port. One transaction is outstanding at a time. Grants are issued by fixed priority or round-robin (compile-time). It replaces the two-port arbiter between the caches and main memory and adds a registered grant stage, explicit per-port completion pulses and grant status outputs.

## Interface
- `NUM_PORTS`, default 2: number of requester ports. Legal values are 2..8.
- `GRANT_W`, default `$clog2(NUM_PORTS)`: width of the grant index. Derived; do not override.

- `clk_i`  input  1  clock
- `reset_i`  input  1  reset, synchronous, active-high
- `req_bus[NUM_PORTS]`  memory_interface.slave  —  requester ports. Port 0 is highest fixed priority; dcache connects to port 0.
- `memory_bus`  memory_interface.master  —  downstream memory
- `grant_valid_o`  output  1  high while a transaction is owned (REQUEST or WAIT)
- `grant_id_o`  output  GRANT_W  index of the owning port; 0 when idle

## Operation
- Memory protocol:
  - Memory holds `ready`=1 when idle.
  - It accepts a request on `valid && ready`, drops `ready` while busy, and raises `ready` again with `rd_data` valid on completion.
- Requester protocol:
  - A requester asserts `valid` with `addr`, `wr_data` and `write`, and holds them stable until its `ready` pulses.
  - It deasserts `valid` on the clock edge that samples the pulse.
- State machine (`state`, reset to READY):
  - READY: `memory_bus.valid`=0 and all `req_bus[k].ready`=0. If `memory_bus.ready` and any `req_bus[k].valid`, select the winner, register `grant_id`, and go to REQUEST. Otherwise stay in READY.
  - REQUEST: drive `memory_bus.addr`, `wr_data`, `write` and `valid` from `req_bus[grant_id]`. When `!memory_bus.ready`, go to WAIT.
  - WAIT: `memory_bus.valid`=0 to prevent re-issue. Address and data stay muxed from the grant. When `memory_bus.ready`, pulse `req_bus[grant_id].ready`=1 for this cycle only, then go to READY.
- `rd_data` is broadcast from `memory_bus.rd_data` to every port. It is meaningful only on the owning port's ready pulse.
- Non-granted ports see `ready`=0 in every state.
- Arbitration:
  - Fixed mode: the lowest index with `valid` wins.
  - Round-robin mode: search starts at `last_grant+1` modulo `NUM_PORTS` and wraps. `last_grant` updates on each READY→REQUEST transition and resets to `NUM_PORTS-1`, so port 0 wins first.
- Requests arriving while a transaction is owned wait in READY. They are never dropped.
- Reset mid-transaction: next state is READY, `grant_valid_o`=0, `grant_id_o`=0, all port readys 0, and `memory_bus.valid`=0 from the cycle after the reset edge. The memory in-flight transaction is abandoned; the memory is reset together with the arbiter.
- `valid` withdrawn by a requester before its pulse is a protocol violation; behaviour is undefined.

## Timing
- Reset values: `memory_bus.valid`=0, `req_bus[*].ready`=0, `grant_valid_o`=0, `grant_id_o`=0. `memory_bus.addr`, `wr_data` and `write` are 0 in READY.
- Arbitration latency is 1 cycle: valid sampled in READY at cycle N, `memory_bus.valid`=1 at N+1.
- Completion pulse lasts exactly 1 cycle, in WAIT, combinationally coincident with `memory_bus.ready` rising.
- Turnaround is 1 READY cycle between consecutive grants.
- Minimum back-to-back period is 4 cycles, for memory with 1 busy cycle.
- No combinational path from `req_bus[*].valid` to `memory_bus.valid` in READY.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration with the `last_grant` pointer.
  - Undefined: fixed priority with port 0 highest, and no `last_grant` register is synthesised.

## Structure
- `memory_arbiter_pkg` holds:
  - the `memory_arbiter_n_state_t` enum (READY, REQUEST, WAIT) as logic [1:0];
  - the `MEMORY_ARBITER_MAX_PORTS`=8 constant.
- Sub-module `rr_priority_picker`:
  - inputs: `req` [NUM_PORTS], `last` [GRANT_W], `rr_en`;
  - outputs: `found`, `idx`;
  - purely combinational, and it selects both fixed and round-robin winners.

## Test plan
- Reset with all valids high: no `memory_bus.valid` during reset. First grant after release goes to port 0, `grant_id_o`=0.
- Single read on port 1 (`addr`=0x100) with memory busy for 3 cycles and `rd_data`=0xDEADBEEF: port 1 gets a 1-cycle ready pulse carrying 0xDEADBEEF, port 0 ready stays 0, and state returns to READY.
- Fixed mode, ports 0 and 1 valid continuously for 4 transactions: grants are 0,0,0,0, so port 1 starves by design.
- Round-robin with `NUM_PORTS`=4 and all valid for 8 transactions: grants are 0,1,2,3,0,1,2,3.
- Round-robin with only ports 1 and 3 valid: grants alternate 1,3,1,3. Port 3 wraps to 1.
- Reset asserted in WAIT: the next cycle shows `memory_bus.valid`=0, `grant_valid_o`=0 and no ready pulse. A fresh request afterwards completes normally.
